// File: rtl/cpu_pkg.sv
// Shared encodings for the instruction-decode front end: opcodes, condition
// codes, multi-transfer commands and instruction field positions.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_LDM  = 4'h8;
  localparam logic [3:0] OP_STM  = 4'h9;
  localparam logic [3:0] OP_B    = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [3:0] {
    COND_AL = 4'h0,
    COND_EQ = 4'h1,
    COND_NE = 4'h2,
    COND_LT = 4'h3,
    COND_GE = 4'h4,
    COND_CS = 4'h5,
    COND_CC = 4'h6,
    COND_MI = 4'h7,
    COND_PL = 4'h8,
    COND_VS = 4'h9,
    COND_VC = 4'hA,
    COND_GT = 4'hB,
    COND_LE = 4'hC,
    COND_NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    LM_HOLD  = 2'b00,
    LM_INIT  = 2'b01,
    LM_STEP  = 2'b10,
    LM_HOLD2 = 2'b11
  } lm_cmd_e;

  localparam int OP_LSB   = 12;
  localparam int RD_LSB   = 8;
  localparam int RS_LSB   = 4;
  localparam int RT_LSB   = 0;
  localparam int FIELD_W  = 4;
  localparam int IMM_W    = 8;

endpackage

// File: rtl/cond_eval.sv
// Branch-condition evaluator: maps a 4-bit condition code and the Z/N/C/V
// flags to a single "take it" bit. Purely combinational.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       z,
  input  logic       n,
  input  logic       c,
  input  logic       v,
  output logic       perform
);

  logic lt;
  assign lt = n ^ v;

  always_comb begin
    perform = 1'b0;
    case (cond)
      COND_AL: perform = 1'b1;
      COND_EQ: perform = z;
      COND_NE: perform = ~z;
      COND_LT: perform = lt;
      COND_GE: perform = ~lt;
      COND_CS: perform = c;
      COND_CC: perform = ~c;
      COND_MI: perform = n;
      COND_PL: perform = ~n;
      COND_VS: perform = v;
      COND_VC: perform = ~v;
      COND_GT: perform = ~z & ~lt;
      COND_LE: perform = z | lt;
      default: perform = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_decode_unit.sv
// Instruction register, condition flags and multi-register transfer counter
// feeding the multicycle control FSM; all outputs come from registers only.
module instr_decode_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IW,
  input  logic [WIDTH-1:0] MemData,
  input  logic             FU,
  input  logic             ALUZ,
  input  logic             ALUN,
  input  logic             ALUC,
  input  logic             ALUV,
  input  logic [1:0]       LM,
  output logic [3:0]       Op,
  output logic [3:0]       Rd,
  output logic [3:0]       Rs,
  output logic [3:0]       Rt,
  output logic [WIDTH-1:0] Imm,
  output logic             Perform,
  output logic             LMC,
  output logic [3:0]       LMReg,
  output logic [WIDTH-1:0] LMOff
);

  logic [WIDTH-1:0] ir;
  logic             flag_z, flag_n, flag_c, flag_v;
  logic [CNTW-1:0]  cnt;
  logic [CNTW-1:0]  cnt_last;

  assign cnt_last = CNTW'(Rt);

  // A step issued together with IW still sees the old Rt, since ir is registered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ir     <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      cnt    <= '0;
    end else begin
      if (IW) ir <= MemData;
      if (FU) {flag_z, flag_n, flag_c, flag_v} <= {ALUZ, ALUN, ALUC, ALUV};
      case (LM)
        LM_INIT: cnt <= '0;
        LM_STEP: if (cnt != cnt_last) cnt <= cnt + CNTW'(1);
        default: ;
      endcase
    end
  end

  assign Op    = ir[OP_LSB +: FIELD_W];
  assign Rd    = ir[RD_LSB +: FIELD_W];
  assign Rs    = ir[RS_LSB +: FIELD_W];
  assign Rt    = ir[RT_LSB +: FIELD_W];
  assign Imm   = {{(WIDTH-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  assign LMC   = (cnt == cnt_last);
  assign LMReg = Rd + 4'(cnt);
  assign LMOff = WIDTH'(cnt);

  cond_eval u_cond_eval (
    .cond    (Rd),
    .z       (flag_z),
    .n       (flag_n),
    .c       (flag_c),
    .v       (flag_v),
    .perform (Perform)
  );

endmodule

// File: tb/tb_instr_decode_unit.sv
// Self-checking bench for instr_decode_unit: directed scenarios plus random
// traffic compared against an abstract model of IR, flags and transfer count.
module tb_instr_decode_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IW = 1'b0;
  logic [15:0] MemData = '0;
  logic        FU = 1'b0;
  logic        ALUZ = 1'b0, ALUN = 1'b0, ALUC = 1'b0, ALUV = 1'b0;
  logic [1:0]  LM = 2'b00;
  logic [3:0]  Op, Rd, Rs, Rt, LMReg;
  logic [15:0] Imm, LMOff;
  logic        Perform, LMC;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_ir;
  logic        m_z, m_n, m_c, m_v;
  int          m_cnt;

  instr_decode_unit #(.WIDTH(16), .CNTW(4)) dut (
    .CLK(CLK), .RESET(RESET), .IW(IW), .MemData(MemData), .FU(FU),
    .ALUZ(ALUZ), .ALUN(ALUN), .ALUC(ALUC), .ALUV(ALUV), .LM(LM),
    .Op(Op), .Rd(Rd), .Rs(Rs), .Rt(Rt), .Imm(Imm), .Perform(Perform),
    .LMC(LMC), .LMReg(LMReg), .LMOff(LMOff)
  );

  always #5 CLK = ~CLK;

  // Branch conditions expressed as signed/unsigned comparison outcomes.
  function automatic logic ref_perform(input logic [3:0] cc, input logic z, n, c, v);
    logic signed_lt;
    signed_lt = (n != v);
    case (cc)
      4'h0: return 1'b1;
      4'h1: return z;
      4'h2: return !z;
      4'h3: return signed_lt;
      4'h4: return !signed_lt;
      4'h5: return c;
      4'h6: return !c;
      4'h7: return n;
      4'h8: return !n;
      4'h9: return v;
      4'hA: return !v;
      4'hB: return !z && !signed_lt;
      4'hC: return z || signed_lt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_ir = '0; m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_cnt = 0;
  endtask

  // Advance one clock edge, updating the model from the pre-edge inputs.
  task automatic tick();
    logic [15:0] nir;
    logic nz, nn, nc, nv;
    int ncnt;
    nir = m_ir; nz = m_z; nn = m_n; nc = m_c; nv = m_v; ncnt = m_cnt;
    if (IW) nir = MemData;
    if (FU) begin nz = ALUZ; nn = ALUN; nc = ALUC; nv = ALUV; end
    if (LM == 2'b01) ncnt = 0;
    else if (LM == 2'b10 && m_cnt != int'(m_ir[3:0])) ncnt = m_cnt + 1;
    @(posedge CLK);
    m_ir = nir; m_z = nz; m_n = nn; m_c = nc; m_v = nv; m_cnt = ncnt;
    #1;
  endtask

  task automatic idle();
    IW = 0; FU = 0; LM = 2'b00;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    IW = 1; MemData = 16'h7ABC; FU = 1; ALUZ = 0; ALUN = 1; LM = 2'b00;
    tick();
    idle();
    checks++;
    if (Op !== 4'h7) begin errors++; $display("FAIL reset_preload Op got %h want 7", Op); end
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({Op, Perform, LMC, LMReg, Imm, LMOff} !== {4'h0, 1'b1, 1'b1, 4'h0, 16'h0, 16'h0}) begin
      errors++;
      $display("FAIL reset_async Op=%h Perform=%b LMC=%b LMReg=%h Imm=%h LMOff=%h want 0 1 1 0 0000 0000",
               Op, Perform, LMC, LMReg, Imm, LMOff);
    end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_decode();
    IW = 1; MemData = 16'h5A37;
    tick();
    checks++;
    if ({Op, Rd, Rs, Rt, Imm} !== {4'h5, 4'hA, 4'h3, 4'h7, 16'h0037}) begin
      errors++;
      $display("FAIL decode_5A37 got %h %h %h %h %h want 5 a 3 7 0037", Op, Rd, Rs, Rt, Imm);
    end
    MemData = 16'h1F80;
    tick();
    checks++;
    if (Imm !== 16'hFF80) begin errors++; $display("FAIL decode_imm_neg got %h want ff80", Imm); end
    IW = 0; MemData = 16'hBEEF;
    tick();
    checks++;
    if ({Op, Rd, Rs, Rt} !== 16'h1F80) begin
      errors++;
      $display("FAIL decode_ir_hold got %h want 1f80", {Op, Rd, Rs, Rt});
    end
  endtask

  task automatic test_conditions();
    logic [15:0] irs [6] = '{16'h0100, 16'h0200, 16'h0B00, 16'h0C00, 16'h0300, 16'h0F00};
    logic        exp [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    FU = 1; ALUZ = 1; ALUN = 0; ALUC = 0; ALUV = 0;
    for (int i = 0; i < 6; i++) begin
      IW = 1; MemData = irs[i];
      if (i == 4) begin FU = 1; ALUZ = 0; ALUN = 1; ALUV = 0; end
      tick();
      FU = 0;
      checks++;
      if (Perform !== exp[i]) begin
        errors++;
        $display("FAIL cond_%h Perform got %b want %b", irs[i][11:8], Perform, exp[i]);
      end
    end
    IW = 0; FU = 1; ALUZ = 1; ALUN = 1; ALUC = 1; ALUV = 1;
    tick();
    FU = 0;
    checks++;
    if (Perform !== 1'b0) begin errors++; $display("FAIL cond_never_all_flags Perform got %b want 0", Perform); end
  endtask

  task automatic test_flag_hold();
    IW = 1; MemData = 16'h0100; FU = 1; ALUZ = 1; ALUN = 0; ALUC = 0; ALUV = 0;
    tick();
    IW = 0; FU = 0;
    for (int i = 0; i < 5; i++) begin
      ALUZ = ~ALUZ; ALUN = $urandom_range(0, 1); ALUC = $urandom_range(0, 1); ALUV = $urandom_range(0, 1);
      tick();
      checks++;
      if (Perform !== 1'b1) begin errors++; $display("FAIL flag_hold_%0d Perform got %b want 1", i, Perform); end
    end
  endtask

  task automatic test_multi_wrap();
    logic [3:0]  reg_exp [4] = '{4'hE, 4'hF, 4'h0, 4'h0};
    logic [15:0] off_exp [4] = '{16'd0, 16'd1, 16'd2, 16'd2};
    logic        lmc_exp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    // Load and init on the same edge: new IR, cleared counter.
    IW = 1; MemData = 16'h0E02; LM = 2'b01;
    tick();
    IW = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({LMReg, LMOff, LMC} !== {reg_exp[i], off_exp[i], lmc_exp[i]}) begin
        errors++;
        $display("FAIL multi_step_%0d LMReg=%h LMOff=%h LMC=%b want %h %h %b",
                 i, LMReg, LMOff, LMC, reg_exp[i], off_exp[i], lmc_exp[i]);
      end
      LM = 2'b10;
      if (i < 3) tick();
    end
    LM = 2'b11;
    tick();
    checks++;
    if ({LMReg, LMC} !== {4'h0, 1'b1}) begin errors++; $display("FAIL multi_hold11 LMReg=%h LMC=%b want 0 1", LMReg, LMC); end
    LM = 2'b01;
    tick();
    checks++;
    if ({LMReg, LMC} !== {4'hE, 1'b0}) begin errors++; $display("FAIL multi_reinit LMReg=%h LMC=%b want e 0", LMReg, LMC); end
    idle();
  endtask

  task automatic test_reset_mid();
    LM = 2'b10;
    tick();
    idle();
    checks++;
    if ({LMReg, LMC} !== {4'hF, 1'b0}) begin errors++; $display("FAIL midrst_pre LMReg=%h LMC=%b want f 0", LMReg, LMC); end
    @(negedge CLK);
    RESET = 1;
    #1;
    model_reset();
    checks++;
    if ({Op, LMC, LMOff, LMReg} !== {4'h0, 1'b1, 16'h0, 4'h0}) begin
      errors++;
      $display("FAIL midrst_async Op=%h LMC=%b LMOff=%h LMReg=%h want 0 1 0000 0", Op, LMC, LMOff, LMReg);
    end
    @(negedge CLK);
    RESET = 0;
    LM = 2'b10;
    tick();
    idle();
    checks++;
    if ({LMOff, LMC} !== {16'h0, 1'b1}) begin errors++; $display("FAIL midrst_step LMOff=%h LMC=%b want 0000 1", LMOff, LMC); end
  endtask

  task automatic test_random();
    logic [15:0] e_imm;
    logic [3:0]  e_reg;
    for (int i = 0; i < 300; i++) begin
      IW = ($urandom_range(0, 5) == 0);
      MemData = 16'($urandom());
      FU = $urandom_range(0, 1);
      {ALUZ, ALUN, ALUC, ALUV} = 4'($urandom());
      LM = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'($urandom());
      tick();
      e_imm = 16'($signed(m_ir[7:0]));
      e_reg = 4'((int'(m_ir[11:8]) + m_cnt) % 16);
      checks++;
      if ({Op, Rd, Rs, Rt, Imm} !== {m_ir, e_imm}) begin
        errors++;
        $display("FAIL rand_decode_%0d got %h%h%h%h %h want %h %h", i, Op, Rd, Rs, Rt, Imm, m_ir, e_imm);
      end
      checks++;
      if (Perform !== ref_perform(m_ir[11:8], m_z, m_n, m_c, m_v)) begin
        errors++;
        $display("FAIL rand_perform_%0d got %b want %b", i, Perform, ref_perform(m_ir[11:8], m_z, m_n, m_c, m_v));
      end
      checks++;
      if ({LMC, LMReg, LMOff} !== {(m_cnt == int'(m_ir[3:0])), e_reg, 16'(m_cnt)}) begin
        errors++;
        $display("FAIL rand_multi_%0d LMC=%b LMReg=%h LMOff=%h want %b %h %h",
                 i, LMC, LMReg, LMOff, (m_cnt == int'(m_ir[3:0])), e_reg, 16'(m_cnt));
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    #12;
    test_reset();
    test_decode();
    test_conditions();
    test_flag_hold();
    test_multi_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decode_unit.md
# instr_decode_unit

Upstream companion of the multicycle `ControlUnit`: latches the fetched instruction, decodes its fields, and produces the three status inputs the control FSM branches on. These are `Op`, `Perform` (branch-condition result) and `LMC` (load/store-multiple complete). It owns the instruction register, the condition-flag register and the multi-register transfer counter. It is steered by the `IW`, `FU` and `LM` control outputs.

## Interface
- `WIDTH`, 16, instruction/data word width
- `CNTW`, 4, multi-register counter width (max 16 transfers)
- `CLK`  in  1  system clock, rising-edge
- `RESET`  in  1  asynchronous, active-high; clears all state
- `IW`  in  1  instruction-register write enable
- `MemData`  in  WIDTH  memory read data (instruction source)
- `FU`  in  1  flag-update enable
- `ALUZ`, `ALUN`, `ALUC`, `ALUV`  in  1 each  ALU zero/negative/carry/overflow
- `LM`  in  2  multi-transfer command: 00 hold, 01 init, 10 step, 11 hold
- `Op`  out  4  IR[15:12]
- `Rd`  out  4  IR[11:8] (also condition code for branches)
- `Rs`  out  4  IR[7:4]
- `Rt`  out  4  IR[3:0] (also transfer count minus one)
- `Imm`  out  WIDTH  sign-extended IR[7:0]
- `Perform`  out  1  condition IR[11:8] satisfied by current flags
- `LMC`  out  1  multi-transfer on final register
- `LMReg`  out  4  register index of current transfer, (Rd + cnt) mod 16
- `LMOff`  out  WIDTH  word offset of current transfer, zero-extended cnt

## Operation
- IR: loads `MemData` on a rising edge with `IW`=1; otherwise holds.
- Flags {Z,N,C,V}: load the ALU inputs on an edge with `FU`=1; otherwise hold.
- `Perform` is combinational from the registered IR[11:8] and flags:
  - 0 always; 1 Z; 2 ~Z; 3 N^V; 4 ~(N^V); 5 C; 6 ~C
  - 7 N; 8 ~N; 9 V; A ~V; B ~Z&~(N^V); C Z|(N^V); D–F never
- Counter `cnt` (CNTW bits):
  - LM=01 sets cnt to 0.
  - LM=10 increments cnt when cnt != Rt; it saturates at Rt.
  - LM=00/11 holds.
- `LMC` = (cnt == Rt), combinational.
- `LMReg` wraps modulo 16 (Rd=F, cnt=1 gives 0).
- Simultaneous `IW` and LM=01: the IR loads the new word and cnt clears. `LMC` then compares against the new Rt from the next cycle on.
- Simultaneous `IW` and LM=10: the step compares against the pre-edge Rt.
- `FU` and `IW` are independent; both take effect on the same edge.

## Timing
- Reset values: IR=0, flags=0, cnt=0. Hence `Op`=0, `Rd`=`Rs`=`Rt`=0, `Imm`=0, `Perform`=1 (cond 0), `LMC`=1, `LMReg`=0, `LMOff`=0.
- A rising `RESET` mid-transfer clears cnt immediately, without waiting for the clock.
- Decode outputs are valid one edge after `IW`, so they are stable throughout the control FSM's decode state.
- A flag written with `FU` on edge n is reflected in `Perform` after edge n. There is no bypass of same-cycle ALU flags.
- `LMC` and `LMReg` update in the cycle after each LM edge. The control FSM samples `LMC` in the same cycle it issues the transfer for `LMReg`.
- All outputs are glitch-free functions of registers only. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants
  - condition-code constants (COND_AL … COND_NV)
  - LM encodings (LM_HOLD, LM_INIT, LM_STEP)
  - field bit-position constants
- One sub-module, `cond_eval`, which is purely combinational: 4-bit cond plus 4 flags in, `Perform` out.
- Everything else lives in `instr_decode_unit`: the IR, flag and counter registers, and the decode assigns.

## Test plan
- Reset: assert `RESET` asynchronously between edges → immediately `Op`=0, `Perform`=1, `LMC`=1, `LMReg`=0.
- Decode: `MemData`=16'h5A37 with `IW`=1 → `Op`=5, `Rd`=A, `Rs`=3, `Rt`=7, `Imm`=16'h0037. Then `MemData`=16'h1F80 → `Imm`=16'hFF80. With `IW`=0 and new `MemData`, the IR is unchanged.
- Conditions: `FU`=1 with Z=1, N=0, V=0, then IR cond=1 → `Perform`=1; cond 2 → 0; cond B → 0; cond C → 1. Set N=1, V=0 → cond 3 `Perform`=1. Cond F → 0 regardless of flags.
- Flag hold: `FU`=0 while the ALU flags toggle → `Perform` unchanged across 5 cycles.
- Multi-transfer wrap: IR=16'h0E02 (Rd=E, Rt=2), LM=01 → `LMReg`=E, `LMC`=0. Step → F, `LMC`=0. Step → 0, `LMOff`=2, `LMC`=1. Extra step → unchanged.
- Reset mid-transfer: after one step of the above, pulse `RESET` → cnt=0, IR=0, `LMC`=1. A following LM=10 leaves cnt at 0.
